// File: rtl/slice_subtractor_12_pkg.sv
// slice_subtractor_12_pkg: default sizes and fsm state type shared by the slice subtractor files
package slice_subtractor_12_pkg;
  localparam int DEF_WIDTH = 12;
  localparam int DEF_SLICE = 3;
  localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/slice_subtractor_12_sub_slice3.sv
// sub_slice3: combinational borrow-ripple stage, d = x - y - bi over SLICE bits, bo = borrow out
module sub_slice3 #(
  parameter int SLICE = 3
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             bi,
  output logic [SLICE-1:0] d,
  output logic             bo
);
  logic [SLICE:0] c;
  always_comb begin
    c = '0;
    d = '0;
    c[0] = bi;
    for (int i = 0; i < SLICE; i++) begin
      d[i] = x[i] ^ y[i] ^ c[i];
      c[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c[i]);
    end
  end
  assign bo = c[SLICE];
endmodule

// File: rtl/slice_subtractor_12.sv
// slice_subtractor_12: serial a-b-bin one slice per cycle; in_valid/in_ready in, out_valid/out_ready with diff,bout out
module slice_subtractor_12
  import slice_subtractor_12_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic borrow_reg;
  logic [SLICE-1:0] d;
  logic bo;
  sub_slice3 #(.SLICE(SLICE)) u_sub (
    .x (a_r[idx*SLICE +: SLICE]),
    .y (b_r[idx*SLICE +: SLICE]),
    .bi(borrow_reg),
    .d (d),
    .bo(bo)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign bout = borrow_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      borrow_reg <= 1'b0;
      diff <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
        borrow_reg <= bin;
        idx <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      diff[idx*SLICE +: SLICE] <= d;
      borrow_reg <= bo;
      idx <= idx == LAST ? idx : idx + 1'b1;
      state <= idx == LAST ? DONE : RUN;
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule
